// File: rtl/alu_issue_stage_if.sv
// Bundle between the decode/issue stage and its surroundings: instruction and
// register-file inputs, pipeline controls, and the registered ID/EX slot outputs.
interface alu_issue_stage_if;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] PCPlus4;
  logic        Stall;
  logic        Flush;
  logic        HazardStall;
  logic [5:0]  ALUOpcode;
  logic        ALURType;
  logic [31:0] ALUA;
  logic [31:0] ALUB;
  logic [4:0]  DestReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic [31:0] LinkAddr;
  logic        OutValid;
  logic        IllegalInstr;

  modport slave (
    input  Instruction, InstrValid, ReadData1, ReadData2, PCPlus4, Stall, Flush,
    output HazardStall, ALUOpcode, ALURType, ALUA, ALUB, DestReg, RegWrite,
           MemRead, MemWrite, MemSize, LinkAddr, OutValid, IllegalInstr
  );

  modport master (
    output Instruction, InstrValid, ReadData1, ReadData2, PCPlus4, Stall, Flush,
    input  HazardStall, ALUOpcode, ALURType, ALUA, ALUB, DestReg, RegWrite,
           MemRead, MemWrite, MemSize, LinkAddr, OutValid, IllegalInstr
  );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS decode/issue stage: decodes the instruction, selects ALU operands and
// registers them into the ID/EX slot, with load-use bubble insertion.
module alu_issue_stage #(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input logic          Clk,
  input logic          Reset,
  alu_issue_stage_if.slave bus
);
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_MUL    = 6'b011100;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b000010;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;

  assign op       = bus.Instruction[31:26];
  assign rs       = bus.Instruction[25:21];
  assign rt       = bus.Instruction[20:16];
  assign rd       = bus.Instruction[15:11];
  assign shamt    = bus.Instruction[10:6];
  assign funct    = bus.Instruction[5:0];
  assign imm      = bus.Instruction[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'd0, imm};

  logic        legal, d_rtype, d_wr, d_mrd, d_mwr, rs_used, rt_used;
  logic [5:0]  d_opc;
  logic [31:0] d_a, d_b;
  logic [4:0]  d_dest;
  logic [1:0]  d_msize;

  always_comb begin
    legal   = 1'b1;
    d_rtype = 1'b0;
    d_opc   = op;
    d_a     = bus.ReadData1;
    d_b     = 32'd0;
    d_dest  = 5'd0;
    d_wr    = 1'b0;
    d_mrd   = 1'b0;
    d_mwr   = 1'b0;
    d_msize = 2'd0;
    rs_used = 1'b1;
    rt_used = 1'b0;
    case (op)
      OP_RTYPE: begin
        d_rtype = 1'b1;
        d_opc   = funct;
        d_b     = bus.ReadData2;
        d_dest  = rd;
        d_wr    = 1'b1;
        rt_used = 1'b1;
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_XOR, F_SLT: legal = 1'b1;
          F_SLL, F_SRL: d_a = {27'd0, shamt};
          F_JR:    d_wr  = 1'b0;
          default: legal = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        // bgez keeps opcode 000001; bltz is encoded as opcode 0 with RType=0
        if (rt == 5'd1)      d_opc = 6'b000001;
        else if (rt == 5'd0) d_opc = 6'b000000;
        else                 legal = 1'b0;
      end
      OP_MUL: begin
        legal   = (funct == F_MUL);
        d_b     = bus.ReadData2;
        d_dest  = rd;
        d_wr    = 1'b1;
        rt_used = 1'b1;
      end
      OP_ADDI, OP_SLTI: begin
        d_b    = imm_sext;
        d_dest = rt;
        d_wr   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d_b    = imm_zext;
        d_dest = rt;
        d_wr   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d_b     = bus.ReadData2;
        rt_used = 1'b1;
      end
      OP_BLEZ, OP_BGTZ, OP_J: begin
        if (op == OP_J) begin
          d_a     = 32'd0;
          rs_used = 1'b0;
        end
      end
      OP_JAL: begin
        d_a     = 32'd0;
        rs_used = 1'b0;
        d_dest  = LINK_REG;
        d_wr    = 1'b1;
      end
      OP_LB, OP_LH, OP_LW: begin
        d_b     = imm_sext;
        d_dest  = rt;
        d_wr    = 1'b1;
        d_mrd   = 1'b1;
        d_msize = (op == OP_LW) ? 2'd2 : (op == OP_LH) ? 2'd1 : 2'd0;
      end
      OP_SB, OP_SH, OP_SW: begin
        d_b     = imm_sext;
        d_mwr   = 1'b1;
        rt_used = 1'b1;
        d_msize = (op == OP_SW) ? 2'd2 : (op == OP_SH) ? 2'd1 : 2'd0;
      end
      default: legal = 1'b0;
    endcase
    if (d_dest == 5'd0) d_wr = 1'b0;
  end

  logic slot_load, hazard_raw, do_issue, do_illegal;

  assign slot_load  = bus.OutValid & bus.MemRead & bus.RegWrite & (bus.DestReg != 5'd0);
  assign hazard_raw = slot_load & bus.InstrValid &
                      ((rs_used & (rs == bus.DestReg)) | (rt_used & (rt == bus.DestReg)));
  assign bus.HazardStall = hazard_raw & ~bus.Stall;

  // Stall does not appear here: when it wins, the slot simply does not load.
  assign do_issue   = ~Reset & ~bus.Flush & ~hazard_raw & bus.InstrValid & legal;
  assign do_illegal = ~Reset & ~bus.Flush & ~hazard_raw & bus.InstrValid & ~legal;

  always_ff @(posedge Clk) begin
    if (Reset || bus.Flush || !bus.Stall) begin
      bus.ALUOpcode    <= do_issue ? d_opc   : 6'd0;
      bus.ALURType     <= do_issue ? d_rtype : 1'b1;
      bus.ALUA         <= do_issue ? d_a     : 32'd0;
      bus.ALUB         <= do_issue ? d_b     : 32'd0;
      bus.DestReg      <= do_issue ? d_dest  : 5'd0;
      bus.RegWrite     <= do_issue & d_wr;
      bus.MemRead      <= do_issue & d_mrd;
      bus.MemWrite     <= do_issue & d_mwr;
      bus.MemSize      <= do_issue ? d_msize : 2'd0;
      bus.LinkAddr     <= do_issue ? bus.PCPlus4 : 32'd0;
      bus.OutValid     <= do_issue;
      bus.IllegalInstr <= do_illegal;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage: stimulus pushes expected slot
// contents per cycle, a monitor pops and compares after each rising edge.
module tb_alu_issue_stage;
  logic Clk = 1'b0;
  logic Reset;
  alu_issue_stage_if bus ();

  alu_issue_stage #(.LINK_REG(5'd31)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic        hz;
    logic [5:0]  opc;
    logic        rtype;
    logic [31:0] a, b;
    logic [4:0]  dest;
    logic        wr, mrd, mwr;
    logic [1:0]  ms;
    logic [31:0] link;
    logic        ov, ill;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec   = 0;

  function automatic exp_t bubble(input logic hz, input logic ill);
    exp_t e;
    e.id = 0; e.hz = hz; e.opc = 6'd0; e.rtype = 1'b1; e.a = 32'd0; e.b = 32'd0;
    e.dest = 5'd0; e.wr = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; e.ms = 2'd0;
    e.link = 32'd0; e.ov = 1'b0; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t iss(input logic [5:0] opc, input logic rtype,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] dest, input logic wr,
                               input logic mrd, input logic mwr,
                               input logic [1:0] ms, input logic [31:0] link);
    exp_t e;
    e.id = 0; e.hz = 1'b0; e.opc = opc; e.rtype = rtype; e.a = a; e.b = b;
    e.dest = dest; e.wr = wr; e.mrd = mrd; e.mwr = mwr; e.ms = ms;
    e.link = link; e.ov = 1'b1; e.ill = 1'b0;
    return e;
  endfunction

  task automatic step(input logic [31:0] instr, input logic valid,
                      input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic [31:0] pc, input logic stall,
                      input logic flush, input logic rst, input exp_t e);
    exp_t x;
    @(negedge Clk);
    bus.Instruction = instr;
    bus.InstrValid  = valid;
    bus.ReadData1   = rd1;
    bus.ReadData2   = rd2;
    bus.PCPlus4     = pc;
    bus.Stall       = stall;
    bus.Flush       = flush;
    Reset           = rst;
    x    = e;
    x.id = vec;
    vec++;
    q.push_back(x);
  endtask

  task automatic cmp(input int id, input string nm,
                     input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %h expected %h", id, nm, got, want);
    end
  endtask

  // Monitor: HazardStall is sampled mid-cycle, slot registers just after the edge.
  initial begin
    logic hz_seen;
    exp_t e;
    forever begin
      @(negedge Clk);
      #1 hz_seen = bus.HazardStall;
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.id, "HazardStall",  {31'd0, hz_seen},          {31'd0, e.hz});
        cmp(e.id, "ALUOpcode",    {26'd0, bus.ALUOpcode},    {26'd0, e.opc});
        cmp(e.id, "ALURType",     {31'd0, bus.ALURType},     {31'd0, e.rtype});
        cmp(e.id, "ALUA",         bus.ALUA,                  e.a);
        cmp(e.id, "ALUB",         bus.ALUB,                  e.b);
        cmp(e.id, "DestReg",      {27'd0, bus.DestReg},      {27'd0, e.dest});
        cmp(e.id, "RegWrite",     {31'd0, bus.RegWrite},     {31'd0, e.wr});
        cmp(e.id, "MemRead",      {31'd0, bus.MemRead},      {31'd0, e.mrd});
        cmp(e.id, "MemWrite",     {31'd0, bus.MemWrite},     {31'd0, e.mwr});
        cmp(e.id, "MemSize",      {30'd0, bus.MemSize},      {30'd0, e.ms});
        cmp(e.id, "LinkAddr",     bus.LinkAddr,              e.link);
        cmp(e.id, "OutValid",     {31'd0, bus.OutValid},     {31'd0, e.ov});
        cmp(e.id, "IllegalInstr", {31'd0, bus.IllegalInstr}, {31'd0, e.ill});
      end
    end
  end

  localparam logic [31:0] I_ADDI = 32'h2109FFFB;
  localparam logic [31:0] I_SLL  = 32'h00095100;
  localparam logic [31:0] I_LW   = 32'h8E080000;
  localparam logic [31:0] I_ADD  = 32'h01084820;
  localparam logic [31:0] I_ORI  = 32'h35088000;
  localparam logic [31:0] I_BGEZ = 32'h04010003;
  localparam logic [31:0] I_BLTZ = 32'h04000000;
  localparam logic [31:0] I_RIX  = 32'h04020000;
  localparam logic [31:0] I_JAL  = 32'h0C000040;
  localparam logic [31:0] I_SW   = 32'hAD090004;
  localparam logic [31:0] I_MUL  = 32'h71095002;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  initial begin
    exp_t lw_e;
    int   guard;
    Reset = 1'b1;
    bus.Instruction = 32'd0; bus.InstrValid = 1'b0; bus.ReadData1 = 32'd0;
    bus.ReadData2 = 32'd0; bus.PCPlus4 = 32'd0; bus.Stall = 1'b0; bus.Flush = 1'b0;

    step(I_ADDI, 1'b0, 32'd10, 32'd0, 32'h100, 1'b0, 1'b0, 1'b1, bubble(1'b0, 1'b0));
    step(I_ADDI, 1'b0, 32'd10, 32'd0, 32'h100, 1'b0, 1'b0, 1'b1, bubble(1'b0, 1'b0));
    step(I_ADDI, 1'b1, 32'd10, 32'd0, 32'h100, 1'b0, 1'b0, 1'b0,
         iss(6'b001000, 1'b0, 32'd10, 32'hFFFFFFFB, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 32'h100));
    step(I_SLL, 1'b1, 32'h77, 32'd3, 32'h104, 1'b0, 1'b0, 1'b0,
         iss(6'b000000, 1'b1, 32'd4, 32'd3, 5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 32'h104));
    step(32'd0, 1'b1, 32'h0, 32'h55, 32'h108, 1'b0, 1'b0, 1'b0,
         iss(6'b000000, 1'b1, 32'd0, 32'h55, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h108));
    step(I_LW, 1'b1, 32'h1000, 32'd0, 32'h10C, 1'b0, 1'b0, 1'b0,
         iss(6'b100011, 1'b0, 32'h1000, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd2, 32'h10C));
    step(I_ADD, 1'b1, 32'd7, 32'd7, 32'h110, 1'b0, 1'b0, 1'b0, bubble(1'b1, 1'b0));
    step(I_ADD, 1'b1, 32'd7, 32'd7, 32'h110, 1'b0, 1'b0, 1'b0,
         iss(6'b100000, 1'b1, 32'd7, 32'd7, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 32'h110));
    step(I_ORI, 1'b1, 32'd1, 32'd0, 32'h114, 1'b0, 1'b0, 1'b0,
         iss(6'b001101, 1'b0, 32'd1, 32'h8000, 5'd8, 1'b1, 1'b0, 1'b0, 2'd0, 32'h114));
    step(I_BGEZ, 1'b1, 32'd0, 32'h9, 32'h118, 1'b0, 1'b0, 1'b0,
         iss(6'b000001, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h118));
    step(I_JAL, 1'b1, 32'h1234, 32'h5, 32'h200, 1'b0, 1'b0, 1'b0,
         iss(6'b000011, 1'b0, 32'd0, 32'd0, 5'd31, 1'b1, 1'b0, 1'b0, 2'd0, 32'h200));

    // Load in the slot, then three stall cycles with a dependent add waiting.
    lw_e = iss(6'b100011, 1'b0, 32'h2000, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd2, 32'h300);
    step(I_LW, 1'b1, 32'h2000, 32'd0, 32'h300, 1'b0, 1'b0, 1'b0, lw_e);
    for (int i = 0; i < 3; i++)
      step(I_ADD, 1'b1, 32'd5, 32'd5, 32'h304, 1'b1, 1'b0, 1'b0, lw_e);
    step(I_ADD, 1'b1, 32'd5, 32'd5, 32'h304, 1'b0, 1'b0, 1'b0, bubble(1'b1, 1'b0));
    step(I_ADD, 1'b1, 32'd5, 32'd5, 32'h304, 1'b0, 1'b0, 1'b0,
         iss(6'b100000, 1'b1, 32'd5, 32'd5, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 32'h304));
    step(I_ADDI, 1'b1, 32'd10, 32'd0, 32'h308, 1'b1, 1'b1, 1'b0, bubble(1'b0, 1'b0));
    step(I_ADDI, 1'b1, 32'd10, 32'd0, 32'h400, 1'b0, 1'b0, 1'b0,
         iss(6'b001000, 1'b0, 32'd10, 32'hFFFFFFFB, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 32'h400));
    step(I_SLL, 1'b1, 32'd0, 32'd3, 32'h404, 1'b0, 1'b0, 1'b1, bubble(1'b0, 1'b0));

    step(I_BAD, 1'b1, 32'd0, 32'd0, 32'h500, 1'b0, 1'b0, 1'b0, bubble(1'b0, 1'b1));
    step(I_ADDI, 1'b1, 32'd10, 32'd0, 32'h504, 1'b0, 1'b0, 1'b0,
         iss(6'b001000, 1'b0, 32'd10, 32'hFFFFFFFB, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 32'h504));
    step(I_BLTZ, 1'b1, 32'h99, 32'h1, 32'h508, 1'b0, 1'b0, 1'b0,
         iss(6'b000000, 1'b0, 32'h99, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h508));
    step(I_RIX, 1'b1, 32'h1, 32'h1, 32'h50C, 1'b0, 1'b0, 1'b0, bubble(1'b0, 1'b1));
    step(I_SW, 1'b1, 32'h40, 32'h77, 32'h510, 1'b0, 1'b0, 1'b0,
         iss(6'b101011, 1'b0, 32'h40, 32'd4, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h510));
    step(I_MUL, 1'b1, 32'd3, 32'd6, 32'h514, 1'b0, 1'b0, 1'b0,
         iss(6'b011100, 1'b0, 32'd3, 32'd6, 5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 32'h514));
    step(I_ADDI, 1'b0, 32'd10, 32'd0, 32'h518, 1'b0, 1'b0, 1'b0, bubble(1'b0, 1'b0));

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge Clk);
      guard++;
    end
    @(negedge Clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
